// File: rtl/sd_command_send_pkg.sv
// Shared definitions for the SD SPI-mode command sender.
package sd_command_send_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StResp,
    StData,
    StDone
  } state_e;

  // Frame framing constants
  localparam logic [1:0] FRAME_START = 2'b01;
  localparam logic       FRAME_STOP  = 1'b1;

  // Command indices used by the host
  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;

  localparam logic [7:0] R1_IDLE = 8'h01;
  localparam logic [7:0] R1_NONE = 8'hFF;

  // First 40 frame bits: start bits, index, argument. CRC7 covers exactly these.
  function automatic logic [39:0] frame_head(input logic [5:0] idx, input logic [31:0] arg);
    return {FRAME_START, idx, arg};
  endfunction

endpackage

// File: rtl/sd_command_send_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, initial value 0), one message bit per enabled cycle.
module sd_crc7 (
  input  logic       clk400,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  // Next-state: clear wins over a shift step.
  always_comb begin
    fb    = bit_in ^ crc_q[6];
    crc_d = crc_q;
    if (clear) begin
      crc_d = 7'd0;
    end else if (enable) begin
      crc_d = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    end
  end

  // CRC register
  always_ff @(posedge clk400 or negedge reset) begin
    if (!reset) begin
      crc_q <= 7'd0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_command_send.sv
// SD SPI-mode command sender: shifts out one 48-bit command frame with CRC7,
// captures R1, and optionally hands off to the block receiver for a data phase.
module sd_command_send
  import sd_command_send_pkg::*;
#(
  parameter int unsigned NCR_MAX      = 64,
  parameter int unsigned DATA_TIMEOUT = 16'hFFFF
) (
  input  logic        clk400,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmdIndex,
  input  logic [31:0] cmdArg,
  input  logic        dataPhase,
  input  logic        SDin,
  output logic        SDout,
  output logic        busy,
  output logic        done,
  output logic [7:0]  response,
  output logic        timeout,
  output logic        rxEnable,
  input  logic        rxDone
);

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  resp_cnt_q, resp_cnt_d;
  logic [7:0]  resp_q, resp_d;
  logic        timeout_q, timeout_d;
  logic        rx_en_q, rx_en_d;
  logic        sdout_q, sdout_d;
  logic [39:0] head_q, head_d;
  logic        data_phase_q, data_phase_d;

  logic        crc_clear, crc_en, crc_bit;
  logic [6:0]  crc;
  logic [5:0]  nxt_bit;
  logic [2:0]  crc_sel;
  logic [7:0]  resp_shift;
  logic [39:0] head_new;

  // CRC is held at zero while idle. Frame bit 0 is always 0, which leaves a zero
  // CRC unchanged, so only bits 1..39 need to be clocked in.
  assign crc_clear = (state_q == StIdle);

  sd_crc7 u_crc7 (
    .clk400 (clk400),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    cnt_d        = cnt_q;
    resp_cnt_d   = resp_cnt_q;
    resp_d       = resp_q;
    timeout_d    = timeout_q;
    rx_en_d      = 1'b0;
    sdout_d      = sdout_q;
    head_d       = head_q;
    data_phase_d = data_phase_q;
    crc_en       = 1'b0;
    crc_bit      = 1'b0;
    nxt_bit      = bit_cnt_q + 6'd1;
    crc_sel      = 3'(6'd46 - nxt_bit);
    resp_shift   = {resp_q[6:0], SDin};
    head_new     = frame_head(cmdIndex, cmdArg);

    unique case (state_q)
      StIdle: begin
        sdout_d = 1'b1;
        if (start) begin
          // Bit 0 goes straight out; the rest of the head waits MSB-aligned.
          sdout_d      = head_new[39];
          head_d       = {head_new[38:0], 1'b0};
          data_phase_d = dataPhase;
          timeout_d    = 1'b0;
          resp_d       = R1_NONE;
          bit_cnt_d    = 6'd0;
          cnt_d        = 16'd0;
          resp_cnt_d   = 3'd0;
          state_d      = StSend;
        end
      end

      StSend: begin
        if (bit_cnt_q == 6'd47) begin
          sdout_d = 1'b1;
          cnt_d   = 16'd0;
          state_d = StWait;
        end else begin
          bit_cnt_d = nxt_bit;
          if (nxt_bit < 6'd40) begin
            sdout_d = head_q[39];
            crc_en  = 1'b1;
            crc_bit = head_q[39];
            head_d  = {head_q[38:0], 1'b0};
          end else if (nxt_bit < 6'd47) begin
            // By bit 40 the CRC register holds the full 40-bit remainder.
            sdout_d = crc[crc_sel];
          end else begin
            sdout_d = FRAME_STOP;
          end
        end
      end

      StWait: begin
        if (!SDin) begin
          resp_d     = resp_shift;
          resp_cnt_d = 3'd1;
          state_d    = StResp;
        end else if (cnt_q == 16'(NCR_MAX - 1)) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StResp: begin
        resp_d     = resp_shift;
        resp_cnt_d = resp_cnt_q + 3'd1;
        if (resp_cnt_q == 3'd7) begin
          if (data_phase_q && (resp_shift == 8'h00)) begin
            rx_en_d = 1'b1;
            cnt_d   = 16'd0;
            state_d = StData;
          end else begin
            state_d = StDone;
          end
        end
      end

      StData: begin
        sdout_d = 1'b1;
        if (rxDone) begin
          state_d = StDone;
        end else if (cnt_q == 16'(DATA_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk400 or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 6'd0;
      cnt_q        <= 16'd0;
      resp_cnt_q   <= 3'd0;
      resp_q       <= R1_NONE;
      timeout_q    <= 1'b0;
      rx_en_q      <= 1'b0;
      sdout_q      <= 1'b1;
      head_q       <= 40'd0;
      data_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      cnt_q        <= cnt_d;
      resp_cnt_q   <= resp_cnt_d;
      resp_q       <= resp_d;
      timeout_q    <= timeout_d;
      rx_en_q      <= rx_en_d;
      sdout_q      <= sdout_d;
      head_q       <= head_d;
      data_phase_q <= data_phase_d;
    end
  end

  assign SDout    = sdout_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign response = resp_q;
  assign timeout  = timeout_q;
  assign rxEnable = rx_en_q;

endmodule

// File: tb/tb_sd_command_send.sv
// Self-checking bench for sd_command_send with a behavioural card model.
module tb_sd_command_send;
  import sd_command_send_pkg::*;

  localparam int NCR = 64;

  logic        clk400 = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmdIndex = 6'd0;
  logic [31:0] cmdArg = 32'd0;
  logic        dataPhase = 1'b0;
  logic        SDin = 1'b1;
  logic        rxDone = 1'b0;
  logic        SDout, busy, done, timeout, rxEnable;
  logic [7:0]  response;

  int n_checks = 0;
  int n_fail = 0;

  sd_command_send #(
    .NCR_MAX      (NCR),
    .DATA_TIMEOUT (65535)
  ) dut (
    .clk400    (clk400),
    .reset     (reset),
    .start     (start),
    .cmdIndex  (cmdIndex),
    .cmdArg    (cmdArg),
    .dataPhase (dataPhase),
    .SDin      (SDin),
    .SDout     (SDout),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .timeout   (timeout),
    .rxEnable  (rxEnable),
    .rxDone    (rxDone)
  );

  always #5 clk400 = ~clk400;

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] exp_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_ref(m), 1'b1};
  endfunction

  // Cycle (counted from the start edge) in which done is expected.
  // 48 frame bit-times, start bit found on wait sample ones+1, 7 further R1
  // bits, then the done cycle; a read adds the rxDone wait.
  function automatic int exp_done_cyc(input int ones, input logic dp, input logic [7:0] r1,
                                      input int rx_delay);
    if (ones >= NCR) return 48 + NCR + 1;
    if (dp && r1 == 8'h00) return 48 + ones + 9 + rx_delay + 1;
    return 48 + ones + 9;
  endfunction

  // Drive one command, play the card, and collect what the DUT did.
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic dp,
                         input int ones, input logic [7:0] r1, input int rx_delay,
                         input bit poke, output logic [47:0] frame, output int done_cyc,
                         output int done_cnt, output int rx_cyc, output int rx_cnt,
                         output logic [7:0] resp, output logic to, output int busy_after);
    frame = '0; done_cyc = 0; done_cnt = 0; rx_cyc = 0; rx_cnt = 0;
    resp = 8'hxx; to = 1'bx; busy_after = 0;
    @(negedge clk400);
    cmdIndex = idx; cmdArg = arg; dataPhase = dp; start = 1'b1; SDin = 1'b1; rxDone = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      int i;
      logic [2:0] sel;
      @(negedge clk400);
      if (cyc <= 48) frame = {frame[46:0], SDout};
      if (rxEnable) begin
        rx_cnt++;
        if (rx_cyc == 0) rx_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          resp = response;
          to = timeout;
        end
      end
      if (done_cyc != 0 && cyc > done_cyc && busy) busy_after++;
      // Stray starts during the frame and in the done cycle carry different fields.
      start = poke && ((cyc >= 5 && cyc <= 7) || cyc == done_cyc);
      if (start) begin
        cmdIndex = ~idx; cmdArg = ~arg; dataPhase = ~dp;
      end
      // Card: value driven now is wait-phase sample number (cyc - 48).
      i = cyc - 48;
      if (i >= ones + 1 && i <= ones + 8) begin
        sel = 3'(ones + 8 - i);
        SDin = r1[sel];
      end else begin
        SDin = 1'b1;
      end
      // A stray rxDone during the frame must be ignored.
      rxDone = (rx_cyc != 0 && cyc == rx_cyc + rx_delay) || cyc == 30;
      if (done_cyc != 0 && cyc >= done_cyc + 60) break;
    end
    start = 1'b0; SDin = 1'b1; rxDone = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk400);
    n_checks++; if (SDout !== 1'b1) begin n_fail++; $display("FAIL reset_sdout: got %b want 1", SDout); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (response !== 8'hFF) begin n_fail++; $display("FAIL reset_resp: got %h want ff", response); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_checks++; if (rxEnable !== 1'b0) begin n_fail++; $display("FAIL reset_rxen: got %b want 0", rxEnable); end
    reset = 1'b1;
  endtask

  task automatic test_cmd0();
    logic [47:0] fr; int dc, dn, rc, rn, ba; logic [7:0] rs; logic tt;
    run_txn(CMD0, 32'd0, 1'b0, 16, R1_IDLE, 0, 1'b0, fr, dc, dn, rc, rn, rs, tt, ba);
    n_checks++; if (fr !== 48'h40_0000_0000_95) begin n_fail++; $display("FAIL cmd0_frame: got %h want 400000000095", fr); end
    n_checks++; if (rs !== 8'h01) begin n_fail++; $display("FAIL cmd0_resp: got %h want 01", rs); end
    n_checks++; if (tt !== 1'b0) begin n_fail++; $display("FAIL cmd0_timeout: got %b want 0", tt); end
    n_checks++; if (dn != 1) begin n_fail++; $display("FAIL cmd0_done_count: got %0d want 1", dn); end
    n_checks++; if (dc != exp_done_cyc(16, 1'b0, 8'h01, 0)) begin
      n_fail++; $display("FAIL cmd0_latency: got %0d want %0d", dc, exp_done_cyc(16, 1'b0, 8'h01, 0));
    end
    n_checks++; if (rn != 0) begin n_fail++; $display("FAIL cmd0_rxen: got %0d want 0", rn); end
  endtask

  task automatic test_cmd8();
    logic [47:0] fr; int dc, dn, rc, rn, ba; logic [7:0] rs; logic tt;
    run_txn(CMD8, 32'h0000_01AA, 1'b0, 0, R1_IDLE, 0, 1'b0, fr, dc, dn, rc, rn, rs, tt, ba);
    n_checks++; if (fr[7:0] !== 8'h87) begin n_fail++; $display("FAIL cmd8_crc_byte: got %h want 87", fr[7:0]); end
    n_checks++; if (fr !== exp_frame(CMD8, 32'h0000_01AA)) begin
      n_fail++; $display("FAIL cmd8_frame: got %h want %h", fr, exp_frame(CMD8, 32'h0000_01AA));
    end
    n_checks++; if (rs !== 8'h01) begin n_fail++; $display("FAIL cmd8_resp: got %h want 01", rs); end
    n_checks++; if (dc != 57) begin n_fail++; $display("FAIL cmd8_latency: got %0d want 57", dc); end
  endtask

  task automatic test_ncr_timeout();
    logic [47:0] fr; int dc, dn, rc, rn, ba; logic [7:0] rs; logic tt;
    // Card never answers.
    run_txn(CMD0, 32'd0, 1'b0, 1000, R1_IDLE, 0, 1'b0, fr, dc, dn, rc, rn, rs, tt, ba);
    n_checks++; if (tt !== 1'b1) begin n_fail++; $display("FAIL ncr_timeout_flag: got %b want 1", tt); end
    n_checks++; if (rs !== 8'hFF) begin n_fail++; $display("FAIL ncr_timeout_resp: got %h want ff", rs); end
    n_checks++; if (dc != 48 + NCR + 1) begin n_fail++; $display("FAIL ncr_timeout_cycle: got %0d want %0d", dc, 48 + NCR + 1); end
    // Start bit on the last allowed sample is accepted.
    run_txn(CMD0, 32'd0, 1'b0, NCR - 1, 8'h01, 0, 1'b0, fr, dc, dn, rc, rn, rs, tt, ba);
    n_checks++; if (tt !== 1'b0) begin n_fail++; $display("FAIL ncr_edge_timeout: got %b want 0", tt); end
    n_checks++; if (rs !== 8'h01) begin n_fail++; $display("FAIL ncr_edge_resp: got %h want 01", rs); end
    // One sample later is too late.
    run_txn(CMD0, 32'd0, 1'b0, NCR, 8'h01, 0, 1'b0, fr, dc, dn, rc, rn, rs, tt, ba);
    n_checks++; if (tt !== 1'b1) begin n_fail++; $display("FAIL ncr_late_timeout: got %b want 1", tt); end
  endtask

  task automatic test_read();
    logic [47:0] fr; int dc, dn, rc, rn, ba; logic [7:0] rs; logic tt;
    run_txn(CMD17, 32'h0000_0200, 1'b1, 3, 8'h00, 100, 1'b0, fr, dc, dn, rc, rn, rs, tt, ba);
    n_checks++; if (rn != 1) begin n_fail++; $display("FAIL read_rxen_count: got %0d want 1", rn); end
    n_checks++; if (rc != 60) begin n_fail++; $display("FAIL read_rxen_cycle: got %0d want 60", rc); end
    n_checks++; if (dc != rc + 101) begin n_fail++; $display("FAIL read_done_cycle: got %0d want %0d", dc, rc + 101); end
    n_checks++; if (tt !== 1'b0) begin n_fail++; $display("FAIL read_timeout: got %b want 0", tt); end
    n_checks++; if (rs !== 8'h00) begin n_fail++; $display("FAIL read_resp: got %h want 00", rs); end
    // Error R1 skips the data phase.
    run_txn(CMD17, 32'h0000_0200, 1'b1, 3, 8'h05, 100, 1'b0, fr, dc, dn, rc, rn, rs, tt, ba);
    n_checks++; if (rn != 0) begin n_fail++; $display("FAIL read_err_rxen: got %0d want 0", rn); end
    n_checks++; if (rs !== 8'h05) begin n_fail++; $display("FAIL read_err_resp: got %h want 05", rs); end
    n_checks++; if (dc != 60) begin n_fail++; $display("FAIL read_err_cycle: got %0d want 60", dc); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] fr; int dc, dn, rc, rn, ba; logic [7:0] rs; logic tt;
    run_txn(CMD8, 32'h0000_01AA, 1'b0, 2, R1_IDLE, 0, 1'b1, fr, dc, dn, rc, rn, rs, tt, ba);
    n_checks++; if (fr !== exp_frame(CMD8, 32'h0000_01AA)) begin
      n_fail++; $display("FAIL b2b_frame: got %h want %h", fr, exp_frame(CMD8, 32'h0000_01AA));
    end
    n_checks++; if (dn != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", dn); end
    n_checks++; if (ba != 0) begin n_fail++; $display("FAIL b2b_busy_after: got %0d want 0", ba); end
    n_checks++; if (rs !== 8'h01) begin n_fail++; $display("FAIL b2b_resp: got %h want 01", rs); end
  endtask

  task automatic test_reset_abort();
    logic [47:0] fr; int dc, dn, rc, rn, ba; logic [7:0] rs; logic tt;
    int done_seen;
    done_seen = 0;
    @(negedge clk400);
    cmdIndex = CMD0; cmdArg = 32'd0; dataPhase = 1'b0; start = 1'b1;
    @(negedge clk400);
    start = 1'b0;
    repeat (20) @(negedge clk400);
    // Frame bit 20 (a zero argument bit) is on the line now.
    reset = 1'b0;
    #1;
    n_checks++; if (SDout !== 1'b1) begin n_fail++; $display("FAIL abort_sdout: got %b want 1", SDout); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (response !== 8'hFF) begin n_fail++; $display("FAIL abort_resp: got %h want ff", response); end
    repeat (3) @(negedge clk400) if (done) done_seen++;
    reset = 1'b1;
    repeat (60) @(negedge clk400) if (done) done_seen++;
    n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_seen); end
    run_txn(CMD0, 32'd0, 1'b0, 5, R1_IDLE, 0, 1'b0, fr, dc, dn, rc, rn, rs, tt, ba);
    n_checks++; if (fr !== 48'h40_0000_0000_95) begin n_fail++; $display("FAIL abort_redo_frame: got %h want 400000000095", fr); end
    n_checks++; if (rs !== 8'h01) begin n_fail++; $display("FAIL abort_redo_resp: got %h want 01", rs); end
  endtask

  task automatic test_random();
    logic [47:0] fr; int dc, dn, rc, rn, ba; logic [7:0] rs; logic tt;
    for (int n = 0; n < 12; n++) begin
      logic [5:0] idx; logic [31:0] arg; logic dp; int ones; logic [7:0] r1; int dly;
      logic [7:0] e_rs; logic e_to; int e_rn;
      idx  = 6'($urandom);
      arg  = $urandom;
      dp   = 1'($urandom_range(0, 1));
      ones = int'($urandom_range(0, 70));
      r1   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
      dly  = int'($urandom_range(0, 20));
      e_rs = (ones < NCR) ? r1 : 8'hFF;
      e_to = (ones >= NCR);
      e_rn = (ones < NCR && dp && r1 == 8'h00) ? 1 : 0;
      run_txn(idx, arg, dp, ones, r1, dly, 1'b0, fr, dc, dn, rc, rn, rs, tt, ba);
      n_checks++; if (fr !== exp_frame(idx, arg)) begin
        n_fail++; $display("FAIL rnd%0d_frame: got %h want %h", n, fr, exp_frame(idx, arg));
      end
      n_checks++; if (rs !== e_rs) begin n_fail++; $display("FAIL rnd%0d_resp: got %h want %h", n, rs, e_rs); end
      n_checks++; if (tt !== e_to) begin n_fail++; $display("FAIL rnd%0d_timeout: got %b want %b", n, tt, e_to); end
      n_checks++; if (rn != e_rn) begin n_fail++; $display("FAIL rnd%0d_rxen: got %0d want %0d", n, rn, e_rn); end
      n_checks++; if (dc != exp_done_cyc(ones, dp, r1, dly)) begin
        n_fail++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", n, dc, exp_done_cyc(ones, dp, r1, dly));
      end
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_ncr_timeout();
    test_read();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_command_send.md
Name: sd_command_send

Overview:
Upstream partner of the SD block receiver. Serialises one 48-bit SD SPI-mode command frame onto MOSI, computing CRC7 on the fly, and captures the 8-bit R1 response from MISO. For read commands it then enables the block receiver and waits for its completion. It runs on the same 400 kHz SPI bit clock as the receiver.

Parameters:
NCR_MAX, 64, maximum MISO bit-times to wait for the R1 start bit before declaring a response timeout.
DATA_TIMEOUT, 16'hFFFF, maximum cycles in the data phase waiting for rxDone before declaring a timeout.

Ports:
clk400  input  1  SPI bit clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request; honoured only in IDLE.
cmdIndex  input  6  command index, latched on an accepted start.
cmdArg  input  32  command argument, latched on an accepted start.
dataPhase  input  1  latched on start; 1 means a data block follows R1.
SDin  input  1  MISO from the card.
SDout  output  1  MOSI to the card; idles high.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle pulse when the transaction ends.
response  output  8  captured R1; held until the next accepted start.
timeout  output  1  valid with done; held until the next accepted start.
rxEnable  output  1  one-cycle enable pulse to the block receiver.
rxDone  input  1  completion indication from the block receiver.

Behaviour:
- Reset (reset low, asynchronous) forces: state IDLE, SDout=1, busy=0, done=0, response=8'hFF, timeout=0, rxEnable=0, all counters 0.
- Frame layout, MSB first: 0, 1, cmdIndex[5:0], cmdArg[31:0], CRC7[6:0], 1.
- CRC7 uses polynomial x^7+x^3+1 with initial value 0. It covers the first 40 bits and is updated one bit per cycle as each bit is shifted out.
- States:
  - IDLE: SDout=1. On start, latch cmdIndex, cmdArg and dataPhase, clear timeout, set response=8'hFF, go to SEND with bitCnt=0.
  - SEND: SDout is registered and presents frame bit bitCnt (bit 0 of the count = first frame bit) during cycles 1..48 after start. After bit 47, go to WAIT. SDout returns to 1.
  - WAIT: sample SDin each cycle.
    - If SDin=0: shift it into response and go to RESP with 1 bit collected.
    - Otherwise, after NCR_MAX samples with no 0 seen: timeout=1, response stays 8'hFF, go to DONE.
  - RESP: shift SDin into response LSB-first-in (left shift) until 8 bits are collected.
    - If dataPhase=1 and response==8'h00: go to DATA and assert rxEnable for exactly that transition cycle.
    - Otherwise go to DONE.
  - DATA: SDout=1. Wait for rxDone=1, then go to DONE. If DATA_TIMEOUT cycles elapse first, set timeout=1 and go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Latency: with an immediate response, done occurs 48 + 1 + 8 + 1 cycles after start (± registered-output offset; the bench checks the exact cycle against this RTL definition).
- Boundaries:
  - start while busy is ignored.
  - start in the same cycle as DONE is ignored; a new command needs IDLE.
  - A start bit found on the NCR_MAX-th sample is accepted, not a timeout.
  - A non-zero R1 with dataPhase=1 skips DATA, and rxEnable is never pulsed.
  - rxDone outside DATA is ignored.
  - Reset mid-frame aborts immediately: SDout=1 and no done pulse.

Decomposition:
- Shared package holds:
  - the state encodings;
  - the frame constants (start bits 2'b01, stop bit 1);
  - the command indices CMD0=0, CMD8=8, CMD17=17;
  - R1_IDLE=8'h01.
- One sub-module: sd_crc7 (serial CRC7, with clear/enable/bit-in inputs and a 7-bit CRC output).

Test Plan:
- CMD0, arg 0, dataPhase=0; SDin high for 16 cycles then byte 0x01 → SDout bytes 40 00 00 00 00 95; response=8'h01; timeout=0; done pulses once.
- CMD8, arg 32'h000001AA → last frame byte 0x87 (CRC7=7'h43); SDin R1 0x01 → response=8'h01.
- SDin held high after CMD0 → done after exactly NCR_MAX wait cycles; timeout=1; response=8'hFF.
- CMD17, arg 32'h00000200, dataPhase=1, R1 0x00 → one rxEnable pulse; rxDone driven 100 cycles later → done next cycle; timeout=0. Repeat with R1 0x05 → no rxEnable; response=8'h05.
- start re-asserted during SEND and in the DONE cycle → frame unaltered; no second transaction.
- reset asserted at frame bit 20 → SDout=1, busy=0 and response=8'hFF immediately; a fresh CMD0 afterwards completes normally.
